// File: rtl/legv8_bus_pkg.sv
// Shared LEGv8 bus definitions: initiator FSM encoding, default widths, strobe counter width.
package legv8_bus_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 64;
   localparam int unsigned DEF_DATA_WIDTH   = 64;
   localparam int unsigned STROBE_CNT_WIDTH = 8;

   typedef enum logic [3:0] {
      IDLE,
      ARB,
      SETUP,
      STROBE,
      HOLD,
      RESP,
      VSETUP,
      VSTROBE,
      VHOLD
   } bus_state_e;

   // States in which the initiator drives address/read/write.
   function automatic logic owns_bus(input bus_state_e s);
      return (s == SETUP) || (s == STROBE) || (s == HOLD) ||
             (s == VSETUP) || (s == VSTROBE) || (s == VHOLD);
   endfunction

endpackage

// File: rtl/bus_strobe_timer.sv
// Strobe-length timer: loads WAIT_CYCLES-1, counts down while enabled, done_c at zero.
module bus_strobe_timer
   import legv8_bus_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic enable,
   output logic done_c
);

   localparam logic [STROBE_CNT_WIDTH-1:0] LOAD_VAL = STROBE_CNT_WIDTH'(WAIT_CYCLES - 1);

   logic [STROBE_CNT_WIDTH-1:0] count;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (enable && (count != '0)) begin
         count <= count - STROBE_CNT_WIDTH'(1);
      end
   end

   assign done_c = (count == '0);

endmodule

// File: rtl/bus_initiator.sv
// Second LEGv8 bus master: turns single request/response transactions into bus read/write cycles.
// Optional write read-back verification is enabled by defining BUS_INITIATOR_VERIFY_EN.
module bus_initiator
   import legv8_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   input  logic                  bus_grant,
   output logic                  bus_own,
   output logic [ADDR_WIDTH-1:0] address,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  read,
   output logic                  write
);

   bus_state_e state, state_next;

   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_buf;
   logic                  drive_q;

   logic accept_c, capture_c, commit_c, rsp_err_c;
   logic timer_load_c, timer_en_c, timer_done_c;

   assign timer_load_c = (state == SETUP) || (state == VSETUP);
   assign timer_en_c   = (state == STROBE) || (state == VSTROBE);

   bus_strobe_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .load   (timer_load_c),
      .enable (timer_en_c),
      .done_c (timer_done_c)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state; grant loss in any owning state aborts straight to RESP.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      capture_c  = 1'b0;
      commit_c   = 1'b0;
      rsp_err_c  = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept_c   = 1'b1;
               state_next = ARB;
            end
         end
         ARB: begin
            if (bus_grant) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else begin
               state_next = STROBE;
            end
         end
         STROBE: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else if (timer_done_c) begin
               state_next = HOLD;
               capture_c  = !write_q;
            end
         end
         HOLD: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else if (write_q) begin
`ifdef BUS_INITIATOR_VERIFY_EN
               state_next = VSETUP;
`else
               state_next = RESP;
`endif
            end else begin
               state_next = RESP;
               commit_c   = 1'b1;
            end
         end
         VSETUP: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else begin
               state_next = VSTROBE;
            end
         end
         VSTROBE: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else if (timer_done_c) begin
               state_next = VHOLD;
               capture_c  = 1'b1;
            end
         end
         VHOLD: begin
            if (!bus_grant) begin
               state_next = RESP;
               rsp_err_c  = 1'b1;
            end else begin
               state_next = RESP;
               commit_c   = 1'b1;
               rsp_err_c  = (rd_buf != wdata_q);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, read capture and registered outputs derived from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_buf    <= '0;
         drive_q   <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
         bus_own   <= 1'b0;
         address   <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
      end else begin
         if (accept_c) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (capture_c) begin
            rd_buf <= data;
         end
         if (commit_c) begin
            rsp_rdata <= rd_buf;
         end
         req_ready <= (state_next == IDLE);
         rsp_valid <= (state_next == RESP);
         rsp_error <= rsp_err_c;
         bus_own   <= owns_bus(state_next);
         address   <= owns_bus(state_next) ? addr_q : '0;
         read      <= ((state_next == STROBE) && !write_q) || (state_next == VSTROBE);
         write     <= (state_next == STROBE) && write_q;
         drive_q   <= write_q &&
                      ((state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD));
      end
   end

   assign data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: memory responder plus transaction-level reference model.
module tb_bus_initiator;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int W = 2;
`ifdef BUS_INITIATOR_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_error;
   logic          bus_grant;
   logic          bus_own;
   logic [AW-1:0] address;
   wire  [DW-1:0] data;
   logic          read;
   logic          write;

   int checks = 0;
   int errors = 0;

   // Responder memory (environment) and the bench's own expected memory.
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] ref_mem [0:255];
   logic [DW-1:0] exp_rdata;
   logic          pre_we;
   logic [7:0]    pre_addr;
   logic [DW-1:0] pre_data;
   logic [DW-1:0] corrupt;

   always #5 clock = ~clock;

   bus_initiator #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .WAIT_CYCLES (W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .bus_grant (bus_grant),
      .bus_own   (bus_own),
      .address   (address),
      .data      (data),
      .read      (read),
      .write     (write)
   );

   always @(posedge clock) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (write) mem[address[7:0]] <= data;
   end

   assign data = read ? (mem[address[7:0]] ^ corrupt) : {DW{1'bz}};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int overlap(input int lo, input int hi, input int last);
      int top;
      top = (hi < last) ? hi : last;
      return (top >= lo) ? (top - lo + 1) : 0;
   endfunction

   function automatic int own_len_of(input bit wr);
      return (wr && VERIFY) ? (2 * W + 4) : (W + 2);
   endfunction

   // One transaction: grant rises at cycle g after accept (0 = already high); d >= 0 drops grant at cycle d.
   task automatic run_txn(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                          input int g, input int d, input string tag);
      int own_len, last_own, k_exp, drv_last, exp_r, exp_w;
      int first_rsp, pulses, reads, writes, both, own_err, addr_err, drv_err, rdy_err;
      bit abort, verify_wr, own_exp, exp_err;
      logic          err_obs;
      logic [63:0]   rdata_obs, readback;
      verify_wr = wr && VERIFY;
      own_len   = own_len_of(wr);
      abort     = (d >= 0);
      last_own  = abort ? d : (g + own_len);
      k_exp     = last_own + 1;
      drv_last  = (last_own < g + W + 2) ? last_own : (g + W + 2);
      first_rsp = -1; pulses = 0; reads = 0; writes = 0; both = 0;
      own_err = 0; addr_err = 0; drv_err = 0; rdy_err = 0;
      err_obs = 1'b0; rdata_obs = '0;

      @(negedge clock);
      check({tag, " req_ready_idle"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
      bus_grant = (g == 0);
      @(posedge clock);
      for (int k = 0; k <= k_exp + 1; k++) begin
         @(negedge clock);
         own_exp = (k >= g + 1) && (k <= last_own);
         if (rsp_valid) begin
            pulses++;
            if (first_rsp < 0) begin
               first_rsp = k;
               err_obs   = rsp_error;
               rdata_obs = rsp_rdata;
            end
         end
         if (read) reads++;
         if (write) writes++;
         if (read && write) both++;
         if (bus_own !== own_exp) own_err++;
         if (address !== (own_exp ? a : 64'd0)) addr_err++;
         if (req_ready !== (k > k_exp)) rdy_err++;
         if (wr && (k >= g + 1) && (k <= drv_last) && (data !== wd)) drv_err++;
         if (wr && (k == k_exp) && (data === wd)) drv_err++;
         if (k == 0) req_valid = 1'b0;
         if ((g > 0) && (k == g)) bus_grant = 1'b1;
         if (abort && (k == d)) bus_grant = 1'b0;
      end

      // Reference model: strobe windows, memory effect, response content.
      exp_w = wr ? overlap(g + 2, g + W + 1, last_own) : 0;
      if (!wr) exp_r = overlap(g + 2, g + W + 1, last_own);
      else if (verify_wr) exp_r = overlap(g + W + 4, g + 2 * W + 3, last_own);
      else exp_r = 0;
      if (exp_w > 0) ref_mem[a[7:0]] = wd;
      readback = ref_mem[a[7:0]] ^ corrupt;
      exp_err  = abort ? 1'b1 : (verify_wr ? (readback != wd) : 1'b0);
      if (!abort && (!wr || verify_wr)) exp_rdata = readback;

      check({tag, " rsp_cycle"}, 64'(first_rsp), 64'(k_exp));
      check({tag, " rsp_pulses"}, 64'(pulses), 64'd1);
      check({tag, " read_cycles"}, 64'(reads), 64'(exp_r));
      check({tag, " write_cycles"}, 64'(writes), 64'(exp_w));
      check({tag, " both_strobes"}, 64'(both), 64'd0);
      check({tag, " bus_own_err"}, 64'(own_err), 64'd0);
      check({tag, " address_err"}, 64'(addr_err), 64'd0);
      check({tag, " data_drive_err"}, 64'(drv_err), 64'd0);
      check({tag, " req_ready_err"}, 64'(rdy_err), 64'd0);
      check({tag, " rsp_error"}, 64'(err_obs), 64'(exp_err));
      check({tag, " rsp_rdata"}, rdata_obs, exp_rdata);
   endtask

   initial begin
      bit wr;
      int g, d, pulses;
      logic [63:0] a, wd, v;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      bus_grant = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; corrupt = '0;
      exp_rdata = '0;

      for (int i = 0; i < 256; i++) begin
         @(negedge clock);
         v = (i == 16) ? 64'h1234 : {$urandom, $urandom};
         pre_we = 1'b1; pre_addr = 8'(i); pre_data = v; ref_mem[i] = v;
      end
      @(negedge clock);
      pre_we = 1'b0;
      @(negedge clock);
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_rdata", rsp_rdata, 64'd0);
      check("reset rsp_error", 64'(rsp_error), 64'd0);
      check("reset bus_own", 64'(bus_own), 64'd0);
      check("reset address", address, 64'd0);
      check("reset read", 64'(read), 64'd0);
      check("reset write", 64'(write), 64'd0);
      reset = 1'b0;

      run_txn(1'b0, 64'h10, 64'h0, 0, -1, "rd_0x10");
      run_txn(1'b1, 64'h20, 64'hABCD, 0, -1, "wr_0x20");
      run_txn(1'b0, 64'h30, 64'h0, 10, -1, "rd_grant_wait");
      run_txn(1'b0, 64'h20, 64'h0, 0, -1, "rd_0x20");
      run_txn(1'b0, 64'h40, 64'h0, 0, 2, "abort_strobe1");
      run_txn(1'b1, 64'h50, 64'h77, 0, 1, "abort_wr_setup");
      run_txn(1'b0, 64'h60, 64'h0, 1, 1 + W + 2, "abort_rd_hold");
`ifdef BUS_INITIATOR_VERIFY_EN
      corrupt = 64'h1;
      run_txn(1'b1, 64'h70, 64'h55, 0, -1, "verify_bad");
      check("verify_bad rdata_0x54", rsp_rdata, 64'h54);
      corrupt = '0;
`endif

      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         wd = {$urandom, $urandom} | 64'h1;
         g  = int'($urandom_range(0, 3));
         d  = ($urandom_range(0, 3) == 0) ? (g + 1 + int'($urandom_range(0, own_len_of(wr) - 1))) : -1;
         run_txn(wr, a, wd, g, d, $sformatf("rand%0d", i));
      end

      // Reset while the read strobe is high kills the request silently.
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h88; req_wdata = '0; bus_grant = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_mid read_in_strobe", 64'(read), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid read", 64'(read), 64'd0);
      check("rst_mid write", 64'(write), 64'd0);
      check("rst_mid bus_own", 64'(bus_own), 64'd0);
      check("rst_mid req_ready", 64'(req_ready), 64'd1);
      check("rst_mid address", address, 64'd0);
      check("rst_mid rsp_rdata", rsp_rdata, 64'd0);
      reset = 1'b0;
      exp_rdata = '0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (rsp_valid) pulses++;
      end
      check("rst_mid no_rsp", 64'(pulses), 64'd0);
      run_txn(1'b0, 64'h10, 64'h0, 0, -1, "rd_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
